// File: rtl/adc_seq_pkg.sv
// Shared types and defaults for the ADC capture sequencer.
// State encoding, channel geometry and index width.
package adc_seq_pkg;

    localparam int NUM_CH_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;
    localparam int CH_IDX_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_STB,
        SCAN
    } seq_state_t;

endpackage

// File: rtl/ch_pick_enc.sv
// Lowest-set-bit priority encoder.
// Picks the next pending channel to put on the stream.
module ch_pick_enc #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] pend,
    output logic [W-1:0] pick_idx,
    output logic         pick_any
);

    assign pick_any = |pend;

    // scan from the top so the lowest set bit is the last writer
    always_comb begin
        pick_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend[i]) pick_idx = W'(i);
        end
    end

endmodule

// File: rtl/adc_capture_sequencer.sv
// Multi-sample ADC capture sequencer.
// Snapshots all channels per strobe and streams enabled ones.
module adc_capture_sequencer
    import adc_seq_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     START,
    input  logic                     STOP,
    input  logic [CNT_W-1:0]         SAMPLE_NUM,
    input  logic [NUM_CH-1:0]        CH_MASK,
    input  logic                     SAMPLE_STB,
    input  logic [NUM_CH*DATA_W-1:0] CH_DATA,
    output logic [DATA_W-1:0]        OUT_DATA,
    output logic [CH_IDX_W-1:0]      OUT_CH,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic                     OUT_LAST,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     OVERRUN
);

    seq_state_t state;

    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [CNT_W-1:0]    num_lat;
    logic [NUM_CH-1:0]   mask_lat;
    logic [NUM_CH-1:0]   pending;
    logic [NUM_CH-1:0]   pend_rest;
    logic [DATA_W-1:0]   snap [NUM_CH];
    logic                stop_flag;
    logic                valid_q;
    logic                done_q;
    logic                ovr_q;
    logic [CH_IDX_W-1:0] pick_idx;
    logic                pick_any;
    logic                hs;
    logic                last_word;
    logic                final_smp;
    logic                finish;
    logic                reload;
    logic                load_snap;

    ch_pick_enc #(
        .N(NUM_CH),
        .W(CH_IDX_W)
    ) u_pick (
        .pend    (pending),
        .pick_idx(pick_idx),
        .pick_any(pick_any)
    );

    assign hs        = valid_q & OUT_READY;
    assign pend_rest = pending & ~(NUM_CH'(1) << pick_idx);
    assign last_word = pick_any & (pend_rest == '0);
    assign cnt_nxt   = cnt + CNT_W'(1);
    assign finish    = (cnt_nxt == num_lat) | stop_flag | STOP;
    assign final_smp = hs & last_word;
    assign reload    = final_smp & ~finish & SAMPLE_STB;
    assign load_snap = ((state == WAIT_STB) & SAMPLE_STB & ~STOP)
                     | reload;

    assign OUT_VALID = valid_q;
    assign OUT_CH    = valid_q ? pick_idx : '0;
    assign OUT_DATA  = (valid_q && pick_any) ? snap[pick_idx] : '0;
    assign OUT_LAST  = valid_q & last_word & finish;
    assign BUSY      = (state != IDLE);
    assign DONE      = done_q;
    assign OVERRUN   = ovr_q;

    // capture all channels on an accepted strobe
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int k = 0; k < NUM_CH; k++) snap[k] <= '0;
        end else if (load_snap) begin
            for (int k = 0; k < NUM_CH; k++) begin
                snap[k] <= CH_DATA[k*DATA_W +: DATA_W];
            end
        end
    end

    // capture sequencing: arm, wait for strobe, drain pending channels
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            num_lat   <= '0;
            mask_lat  <= '0;
            pending   <= '0;
            stop_flag <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (START) begin
                        if (SAMPLE_NUM != '0 && CH_MASK != '0) begin
                            num_lat   <= SAMPLE_NUM;
                            mask_lat  <= CH_MASK;
                            cnt       <= '0;
                            ovr_q     <= 1'b0;
                            stop_flag <= 1'b0;
                            state     <= WAIT_STB;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                WAIT_STB: begin
                    if (STOP) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end else if (SAMPLE_STB) begin
                        pending <= mask_lat;
                        valid_q <= 1'b1;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (STOP) stop_flag <= 1'b1;
                    if (SAMPLE_STB && !reload) ovr_q <= 1'b1;
                    if (hs) pending <= pend_rest;
                    if (final_smp) begin
                        cnt       <= cnt_nxt;
                        stop_flag <= 1'b0;
                        if (finish) begin
                            state   <= IDLE;
                            done_q  <= 1'b1;
                            valid_q <= 1'b0;
                        end else if (SAMPLE_STB) begin
                            pending <= mask_lat;
                        end else begin
                            state   <= WAIT_STB;
                            valid_q <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Randomized bench for adc_capture_sequencer.
// Queue-based reference model of the word stream.
module tb_adc_capture_sequencer;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         START;
    logic         STOP;
    logic [15:0]  SAMPLE_NUM;
    logic [15:0]  CH_MASK;
    logic         SAMPLE_STB;
    logic [255:0] CH_DATA;
    logic [15:0]  OUT_DATA;
    logic [3:0]   OUT_CH;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic         OUT_LAST;
    logic         BUSY;
    logic         DONE;
    logic         OVERRUN;

    adc_capture_sequencer dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .STOP      (STOP),
        .SAMPLE_NUM(SAMPLE_NUM),
        .CH_MASK   (CH_MASK),
        .SAMPLE_STB(SAMPLE_STB),
        .CH_DATA   (CH_DATA),
        .OUT_DATA  (OUT_DATA),
        .OUT_CH    (OUT_CH),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_LAST  (OUT_LAST),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .OVERRUN   (OVERRUN)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit          m_active;
    bit          m_stop;
    bit          m_done;
    bit          m_ovr;
    int          m_num;
    logic [15:0] m_mask;
    int          m_smp;
    int          qc[$];
    logic [15:0] qd[$];
    int          words;
    int          done_seen;
    bit          fix_data;
    logic [15:0] p_num;
    logic [15:0] p_mask;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_stop   = 0;
        m_done   = 0;
        m_ovr    = 0;
        m_num    = 0;
        m_mask   = '0;
        m_smp    = 0;
        qc.delete();
        qd.delete();
    endtask

    task automatic push_sample();
        for (int k = 0; k < 16; k++) begin
            if (m_mask[k]) begin
                qc.push_back(k);
                qd.push_back(CH_DATA[k*16 +: 16]);
            end
        end
    endtask

    task automatic step(input bit st, input bit sp, input bit sb,
                        input bit rd);
        bit exp_last;
        bit hs;
        bit stop_now;
        bit acc;
        @(negedge CLK);
        START      = st;
        STOP       = sp;
        SAMPLE_STB = sb;
        OUT_READY  = rd;
        SAMPLE_NUM = p_num;
        CH_MASK    = p_mask;
        if (!fix_data) begin
            for (int k = 0; k < 16; k++) CH_DATA[k*16 +: 16] = 16'($urandom);
        end
        #1;
        chk("valid", OUT_VALID, qc.size() != 0);
        if (qc.size() != 0) begin
            exp_last = (qc.size() == 1) &&
                       ((m_smp + 1 == m_num) || m_stop || sp);
            chk("ch", OUT_CH, qc[0]);
            chk("data", OUT_DATA, qd[0]);
            chk("last", OUT_LAST, exp_last);
        end else begin
            chk("last_idle", OUT_LAST, 0);
        end
        chk("busy", BUSY, m_active);
        chk("done", DONE, m_done);
        chk("overrun", OVERRUN, m_ovr);
        done_seen += DONE;
        // advance the model across the coming clock edge
        m_done = 0;
        hs = (qc.size() != 0) && rd;
        if (!m_active) begin
            if (st) begin
                if (p_num != 0 && p_mask != 0) begin
                    m_active = 1;
                    m_num    = p_num;
                    m_mask   = p_mask;
                    m_smp    = 0;
                    m_ovr    = 0;
                    m_stop   = 0;
                end else begin
                    m_done = 1;
                end
            end
        end else if (qc.size() == 0) begin
            if (sp) begin
                m_active = 0;
                m_done   = 1;
            end else if (sb) begin
                push_sample();
            end
        end else begin
            stop_now = m_stop || sp;
            if (sp) m_stop = 1;
            acc = 0;
            if (hs) begin
                void'(qc.pop_front());
                void'(qd.pop_front());
                words++;
                if (qc.size() == 0) begin
                    m_smp++;
                    m_stop = 0;
                    if (m_smp == m_num || stop_now) begin
                        m_active = 0;
                        m_done   = 1;
                    end else if (sb) begin
                        acc = 1;
                        push_sample();
                    end
                end
            end
            if (sb && !acc) m_ovr = 1;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        chk("rst_valid", OUT_VALID, 0);
        chk("rst_data", OUT_DATA, 0);
        chk("rst_ch", OUT_CH, 0);
        chk("rst_last", OUT_LAST, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_ovr", OVERRUN, 0);
        model_reset();
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic begin_phase(input logic [15:0] n, input logic [15:0] m);
        p_num     = n;
        p_mask    = m;
        words     = 0;
        done_seen = 0;
    endtask

    function automatic int popc(input logic [15:0] v);
        int c = 0;
        for (int k = 0; k < 16; k++) c += int'(v[k]);
        return c;
    endfunction

    initial begin
        logic [15:0] rmask;
        bit          stop_sent;
        RESET      = 1'b1;
        START      = 0;
        STOP       = 0;
        SAMPLE_STB = 0;
        OUT_READY  = 0;
        SAMPLE_NUM = '0;
        CH_MASK    = '0;
        CH_DATA    = '0;
        fix_data   = 0;
        model_reset();
        #12;
        chk("por_valid", OUT_VALID, 0);
        chk("por_busy", BUSY, 0);
        chk("por_done", DONE, 0);
        chk("por_ovr", OVERRUN, 0);
        @(negedge CLK);
        RESET = 1'b0;

        // basic: two samples, full mask, fixed data
        fix_data = 1;
        for (int k = 0; k < 16; k++) CH_DATA[k*16 +: 16] = 16'h1000 + 16'(k);
        begin_phase(16'd2, 16'hFFFF);
        step(1, 0, 0, 1);
        for (int c = 0; c < 90; c++) step(0, 0, c == 5 || c == 45, 1);
        chk("basic_words", words, 32);
        chk("basic_dones", done_seen, 1);
        fix_data = 0;

        // sparse mask with toggling ready
        begin_phase(16'd3, 16'h8421);
        step(1, 0, 0, 1);
        for (int c = 0; c < 100; c++) step(0, 0, c % 30 == 3, c % 2 == 0);
        chk("sparse_words", words, 12);
        chk("sparse_dones", done_seen, 1);

        // overrun: strobes far faster than the scan
        begin_phase(16'd4, 16'hFFFF);
        step(1, 0, 0, 1);
        for (int c = 0; c < 120; c++) step(0, 0, c % 2 == 0, 1);
        chk("ovr_words", words, 64);
        chk("ovr_flag", OVERRUN, 1);

        // back-to-back strobe on the final handshake
        begin_phase(16'd2, 16'h0003);
        step(1, 0, 0, 1);
        for (int c = 0; c < 30; c++) begin
            step(0, 0, c == 2 || (m_active && m_smp == 0 && qc.size() == 1), 1);
        end
        chk("b2b_words", words, 4);
        chk("b2b_ovr", OVERRUN, 0);

        // STOP during the scan of sample 3 of 10
        rmask = 16'($urandom) | 16'h0001;
        begin_phase(16'd10, rmask);
        stop_sent = 0;
        step(1, 0, 0, 1);
        for (int c = 0; c < 260; c++) begin
            if (!stop_sent && m_smp == 2 && qc.size() > 0) begin
                stop_sent = 1;
                step(0, 1, 0, 1'($urandom));
            end else begin
                step(0, 0, c % 40 == 3, 1'($urandom));
            end
        end
        chk("stop_words", words, 3 * popc(rmask));
        chk("stop_dones", done_seen, 1);

        // STOP while waiting for a strobe
        begin_phase(16'd5, 16'hFFFF);
        step(1, 0, 0, 1);
        for (int c = 0; c < 5; c++) step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        for (int c = 0; c < 10; c++) step(0, 0, c == 3, 1);
        chk("wstop_words", words, 0);
        chk("wstop_dones", done_seen, 1);

        // zero-length capture
        begin_phase(16'd0, 16'hFFFF);
        step(1, 0, 0, 1);
        for (int c = 0; c < 6; c++) step(0, 0, c == 2, 1);
        chk("zero_words", words, 0);
        chk("zero_dones", done_seen, 1);

        // START while busy is ignored
        begin_phase(16'd1, 16'h0001);
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        p_num  = 16'd5;
        p_mask = 16'hFFFF;
        step(1, 0, 0, 1);
        for (int c = 0; c < 12; c++) step(0, 0, c == 3, 1);
        chk("busy_start_words", words, 1);

        // reset in the middle of a scan
        begin_phase(16'd5, 16'hFFFF);
        step(1, 0, 0, 1);
        for (int c = 0; c < 8; c++) step(0, 0, c == 2, 1);
        chk("pre_rst_busy", BUSY, 1);
        do_reset();
        for (int c = 0; c < 4; c++) step(0, 0, 1, 1);

        // random soak
        for (int c = 0; c < 4000; c++) begin
            if ($urandom % 8 == 0) p_num = 16'($urandom % 5);
            if ($urandom % 97 == 0) p_num = 16'hFFFF;
            if ($urandom % 8 == 0) begin
                p_mask = ($urandom % 8 == 0) ? 16'h0 : 16'($urandom & $urandom);
            end
            step($urandom % 20 == 0, $urandom % 60 == 0,
                 $urandom % 6 == 0, $urandom % 4 != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
